// File: rtl/alarm_ring_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared state encoding and default time geometry for the
//                alarm clock datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int c_max_minutes = 60;
    localparam int c_max_hours   = 24;
    localparam int c_min_w       = $clog2(c_max_minutes);
    localparam int c_hr_w        = $clog2(c_max_hours);

endpackage
`default_nettype wire

// File: rtl/btn_press_detect.sv
`default_nettype none
// ============================================================================
//  Module      : btn_press_detect
//  Description : Two-flop synchronizer for an active-low push button followed
//                by a falling-edge detector; one pulse per press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_press_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press
);

    logic r_sync0;
    logic r_sync1;
    logic r_prev;

    // Flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync0 <= i_btn_n;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
        end
    end

    assign o_press = r_prev & ~r_sync1;

endmodule
`default_nettype wire

// File: rtl/alarm_ring_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ring_scheduler
//  Description : Stores the alarm time, compares it with the running clock and
//                sequences the buzzer through arm / ring / snooze / timeout.
//                Snooze support is built only when ALARM_SNOOZE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_scheduler
    import clock_pkg::*;
#(
    parameter int MAX_MINUTES    = c_max_minutes,
    parameter int MAX_HOURS      = c_max_hours,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sec_tick,
    input  logic [$clog2(MAX_MINUTES)-1:0] cur_minutes,
    input  logic [$clog2(MAX_HOURS)-1:0]   cur_hours,
    input  logic                           alarm_enable,
    input  logic                           set_alarm,
    input  logic [$clog2(MAX_MINUTES)-1:0] alarm_minutes_in,
    input  logic [$clog2(MAX_HOURS)-1:0]   alarm_hours_in,
    input  logic                           stop_btn,
    input  logic                           snooze_btn,
    output logic                           buzzer,
    output logic                           alarm_armed,
    output logic                           snooze_active,
    output logic [$clog2(MAX_MINUTES)-1:0] alarm_minutes,
    output logic [$clog2(MAX_HOURS)-1:0]   alarm_hours,
    output logic [1:0]                     state_o
);

    // The package widths describe the default geometry; other geometries derive their own.
    localparam int c_mw = (MAX_MINUTES == c_max_minutes) ? c_min_w : $clog2(MAX_MINUTES);
    localparam int c_hw = (MAX_HOURS == c_max_hours) ? c_hr_w : $clog2(MAX_HOURS);
    localparam int c_cw = $clog2(RING_SECONDS + 1);

    localparam logic [c_cw-1:0] c_ring_last = c_cw'(RING_SECONDS - 1);

    alarm_state_t    r_state;
    alarm_state_t    w_state_nxt;
    logic [c_mw-1:0] r_alarm_min;
    logic [c_hw-1:0] r_alarm_hr;
    logic [c_mw-1:0] r_tgt_min;
    logic [c_hw-1:0] r_tgt_hr;
    logic [c_mw-1:0] w_tgt_min_nxt;
    logic [c_hw-1:0] w_tgt_hr_nxt;
    logic            r_fired;
    logic [c_cw-1:0] r_ring_cnt;
    logic            w_time_eq;
    logic            w_match;
    logic            w_timeout;
    logic            w_enter_ring;
    logic            w_stop_press;

    btn_press_detect u_stop_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (stop_btn),
        .o_press (w_stop_press)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int              c_mw1       = c_mw + 1;
    localparam int              c_hw1       = c_hw + 1;
    localparam logic [c_mw:0]   c_snz_add   = c_mw1'(SNOOZE_MINUTES);
    localparam logic [c_mw:0]   c_min_lim   = c_mw1'(MAX_MINUTES);
    localparam logic [c_hw:0]   c_hr_lim    = c_hw1'(MAX_HOURS);

    logic            w_snooze_press;
    logic [c_mw:0]   w_snz_sum_min;
    logic            w_snz_carry;
    logic [c_mw-1:0] w_snz_min;
    logic [c_hw:0]   w_snz_sum_hr;
    logic [c_hw-1:0] w_snz_hr;

    btn_press_detect u_snooze_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (snooze_btn),
        .o_press (w_snooze_press)
    );

    // Wide sum plus one conditional subtract gives the wrap without a divider.
    assign w_snz_sum_min = {1'b0, cur_minutes} + c_snz_add;
    assign w_snz_carry   = (w_snz_sum_min >= c_min_lim);
    assign w_snz_min     = w_snz_carry ? c_mw'(w_snz_sum_min - c_min_lim)
                                       : w_snz_sum_min[c_mw-1:0];
    assign w_snz_sum_hr  = {1'b0, cur_hours} + {{c_hw{1'b0}}, w_snz_carry};
    assign w_snz_hr      = (w_snz_sum_hr >= c_hr_lim) ? c_hw'(w_snz_sum_hr - c_hr_lim)
                                                      : w_snz_sum_hr[c_hw-1:0];
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze_btn ^ (SNOOZE_MINUTES > 0);
`endif

    assign w_time_eq = (cur_hours == r_tgt_hr) && (cur_minutes == r_tgt_min);
    assign w_match   = w_time_eq && !r_fired;
    assign w_timeout = sec_tick && (r_ring_cnt == c_ring_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_tgt_min_nxt = r_tgt_min;
        w_tgt_hr_nxt  = r_tgt_hr;
        w_enter_ring  = 1'b0;

        if (set_alarm) begin
            w_tgt_min_nxt = alarm_minutes_in;
            w_tgt_hr_nxt  = alarm_hours_in;
        end else if (r_state == IDLE) begin
            w_tgt_min_nxt = r_alarm_min;
            w_tgt_hr_nxt  = r_alarm_hr;
        end

        if (!alarm_enable) begin
            w_state_nxt = IDLE;
        end else if (set_alarm) begin
            w_state_nxt = ARMED;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARMED;
                end
                ARMED: begin
                    if (w_match) begin
                        w_state_nxt  = RINGING;
                        w_enter_ring = 1'b1;
                    end
                end
                RINGING: begin
                    if (w_stop_press) begin
                        w_state_nxt   = ARMED;
                        w_tgt_min_nxt = r_alarm_min;
                        w_tgt_hr_nxt  = r_alarm_hr;
`ifdef ALARM_SNOOZE_EN
                    end else if (w_snooze_press) begin
                        w_state_nxt   = SNOOZE;
                        w_tgt_min_nxt = w_snz_min;
                        w_tgt_hr_nxt  = w_snz_hr;
`endif
                    end else if (w_timeout) begin
                        w_state_nxt   = ARMED;
                        w_tgt_min_nxt = r_alarm_min;
                        w_tgt_hr_nxt  = r_alarm_hr;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (w_stop_press) begin
                        w_state_nxt   = ARMED;
                        w_tgt_min_nxt = r_alarm_min;
                        w_tgt_hr_nxt  = r_alarm_hr;
                    end else if (w_match) begin
                        w_state_nxt  = RINGING;
                        w_enter_ring = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alarm_min <= '0;
            r_alarm_hr  <= '0;
            r_tgt_min   <= '0;
            r_tgt_hr    <= '0;
            r_fired     <= 1'b0;
            r_ring_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tgt_min <= w_tgt_min_nxt;
            r_tgt_hr  <= w_tgt_hr_nxt;

            if (set_alarm) begin
                r_alarm_min <= alarm_minutes_in;
                r_alarm_hr  <= alarm_hours_in;
            end

            // Latch stays set for the rest of the matching minute to block a re-trigger.
            if (set_alarm) begin
                r_fired <= 1'b0;
            end else if (w_enter_ring) begin
                r_fired <= 1'b1;
            end else if (!w_time_eq) begin
                r_fired <= 1'b0;
            end

            if (w_enter_ring) begin
                r_ring_cnt <= '0;
            end else if ((r_state == RINGING) && sec_tick) begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
            end
        end
    end

    assign buzzer        = (r_state == RINGING);
    assign alarm_armed   = (r_state == ARMED) || (r_state == SNOOZE);
`ifdef ALARM_SNOOZE_EN
    assign snooze_active = (r_state == SNOOZE);
`else
    assign snooze_active = 1'b0;
`endif
    assign alarm_minutes = r_alarm_min;
    assign alarm_hours   = r_alarm_hr;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ring_scheduler
//  Description : Directed scenarios plus randomized traffic against a
//                minutes-of-day reference model of the alarm scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_scheduler;

    localparam int RS  = 4;
    localparam int SNZ = 5;
    localparam int MM  = 60;
    localparam int MH  = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic [5:0] cur_minutes = '0;
    logic [4:0] cur_hours = '0;
    logic       alarm_enable = 1'b0;
    logic       set_alarm = 1'b0;
    logic [5:0] alarm_minutes_in = '0;
    logic [4:0] alarm_hours_in = '0;
    logic       stop_btn = 1'b1;
    logic       snooze_btn = 1'b1;
    logic       buzzer;
    logic       alarm_armed;
    logic       snooze_active;
    logic [5:0] alarm_minutes;
    logic [4:0] alarm_hours;
    logic [1:0] state_o;

    alarm_ring_scheduler #(
        .MAX_MINUTES    (MM),
        .MAX_HOURS      (MH),
        .RING_SECONDS   (RS),
        .SNOOZE_MINUTES (SNZ)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sec_tick         (sec_tick),
        .cur_minutes      (cur_minutes),
        .cur_hours        (cur_hours),
        .alarm_enable     (alarm_enable),
        .set_alarm        (set_alarm),
        .alarm_minutes_in (alarm_minutes_in),
        .alarm_hours_in   (alarm_hours_in),
        .stop_btn         (stop_btn),
        .snooze_btn       (snooze_btn),
        .buzzer           (buzzer),
        .alarm_armed      (alarm_armed),
        .snooze_active    (snooze_active),
        .alarm_minutes    (alarm_minutes),
        .alarm_hours      (alarm_hours),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: times held as minutes since midnight; state as 0..3.
    int m_state = 0;
    int m_saved = 0;
    int m_tgt   = 0;
    int m_cnt   = 0;
    bit m_fired = 1'b0;
    bit st_h1 = 1'b1, st_h2 = 1'b1, st_h3 = 1'b1;
    bit sn_h1 = 1'b1, sn_h2 = 1'b1, sn_h3 = 1'b1;

    task automatic model_edge();
        int cur, nin, n_state, n_tgt;
        bit sp, np, match, tmo, enter;
        cur = int'(cur_hours) * MM + int'(cur_minutes);
        nin = int'(alarm_hours_in) * MM + int'(alarm_minutes_in);
        if (rst) begin
            m_state = 0; m_saved = 0; m_tgt = 0; m_cnt = 0; m_fired = 1'b0;
            st_h1 = 1'b1; st_h2 = 1'b1; st_h3 = 1'b1;
            sn_h1 = 1'b1; sn_h2 = 1'b1; sn_h3 = 1'b1;
            return;
        end
        // A press reaches the FSM two edges after the pin was first seen low.
        sp = !st_h2 && st_h3;
`ifdef ALARM_SNOOZE_EN
        np = !sn_h2 && sn_h3;
`else
        np = 1'b0;
`endif
        st_h3 = st_h2; st_h2 = st_h1; st_h1 = stop_btn;
        sn_h3 = sn_h2; sn_h2 = sn_h1; sn_h1 = snooze_btn;
        match   = (cur == m_tgt) && !m_fired;
        tmo     = sec_tick && (m_cnt + 1 == RS);
        n_state = m_state;
        n_tgt   = (m_state == 0) ? m_saved : m_tgt;
        enter   = 1'b0;
        if (set_alarm) n_tgt = nin;
        if (!alarm_enable) n_state = 0;
        else if (set_alarm) n_state = 1;
        else if (m_state == 0) n_state = 1;
        else if (m_state == 1) begin
            if (match) begin n_state = 2; enter = 1'b1; end
        end else if (m_state == 2) begin
            if (sp) begin n_state = 1; n_tgt = m_saved; end
            else if (np) begin n_state = 3; n_tgt = (cur + SNZ) % (MM * MH); end
            else if (tmo) begin n_state = 1; n_tgt = m_saved; end
        end else begin
            if (sp) begin n_state = 1; n_tgt = m_saved; end
            else if (match) begin n_state = 2; enter = 1'b1; end
        end
        if (set_alarm) m_fired = 1'b0;
        else if (enter) m_fired = 1'b1;
        else if (cur != m_tgt) m_fired = 1'b0;
        if (enter) m_cnt = 0;
        else if (m_state == 2 && sec_tick) m_cnt = m_cnt + 1;
        if (set_alarm) m_saved = nin;
        m_state = n_state;
        m_tgt   = n_tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_time(input int h, input int m);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
    endtask

    // Loads the alarm at the current time and lets it fire.
    task automatic arm_and_ring(input int h, input int m);
        set_time(h, m);
        alarm_enable     = 1'b1;
        alarm_hours_in   = 5'(h);
        alarm_minutes_in = 6'(m);
        set_alarm        = 1'b1;
        tick();
        set_alarm = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %0d expected 0", buzzer); end
        checks++; if (alarm_armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %0d expected 0", alarm_armed); end
        checks++; if (snooze_active !== 1'b0) begin errors++; $display("FAIL reset_snooze: got %0d expected 0", snooze_active); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if ({alarm_hours, alarm_minutes} !== 11'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d expected 0:0", alarm_hours, alarm_minutes); end
    endtask

    task automatic test_basic_ring();
        set_time(7, 0);
        alarm_enable     = 1'b1;
        alarm_hours_in   = 5'd7;
        alarm_minutes_in = 6'd30;
        set_alarm        = 1'b1;
        tick();
        set_alarm = 1'b0;
        checks++; if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30) begin errors++; $display("FAIL basic_saved_time: got %0d:%0d expected 7:30", alarm_hours, alarm_minutes); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_armed: got %0d expected 1", state_o); end
        ticks(3);
        set_time(7, 30);
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL basic_no_early_buzz: got %0d expected 0", buzzer); end
        tick();
        checks++; if (buzzer !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL basic_ring: got buzzer %0d state %0d expected 1/2", buzzer, state_o); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < RS - 1; i++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            tick();
        end
        checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL timeout_early: got %0d expected 1", buzzer); end
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        checks++; if (buzzer !== 1'b0 || state_o !== 2'd1) begin errors++; $display("FAIL timeout_fall: got buzzer %0d state %0d expected 0/1", buzzer, state_o); end
        ticks(5);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL timeout_no_rering: got %0d expected 1", state_o); end
        set_time(7, 31);
        ticks(2);
    endtask

    task automatic test_button_priority();
        arm_and_ring(7, 35);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL prio_ringing: got %0d expected 2", state_o); end
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        ticks(2);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL prio_sync_latency: got %0d expected 2", state_o); end
        tick();
        checks++; if (state_o !== 2'd1 || snooze_active !== 1'b0) begin errors++; $display("FAIL prio_stop_wins: got state %0d snooze %0d expected 1/0", state_o, snooze_active); end
        ticks(3);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL prio_held_single: got %0d expected 1", state_o); end
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        ticks(3);
    endtask

    task automatic test_set_while_ringing();
        arm_and_ring(7, 40);
        alarm_hours_in   = 5'd8;
        alarm_minutes_in = 6'd0;
        set_alarm        = 1'b1;
        tick();
        set_alarm = 1'b0;
        checks++; if (buzzer !== 1'b0 || state_o !== 2'd1) begin errors++; $display("FAIL set_ring_state: got buzzer %0d state %0d expected 0/1", buzzer, state_o); end
        checks++; if (alarm_hours !== 5'd8 || alarm_minutes !== 6'd0) begin errors++; $display("FAIL set_ring_time: got %0d:%0d expected 8:0", alarm_hours, alarm_minutes); end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze_wrap();
        arm_and_ring(23, 58);
        snooze_btn = 1'b0;
        ticks(3);
        snooze_btn = 1'b1;
        checks++; if (state_o !== 2'd3 || snooze_active !== 1'b1 || alarm_armed !== 1'b1) begin errors++; $display("FAIL snooze_enter: got state %0d snz %0d armed %0d expected 3/1/1", state_o, snooze_active, alarm_armed); end
        set_time(0, 2);
        ticks(3);
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL snooze_wait: got %0d expected 3", state_o); end
        set_time(0, 3);
        tick();
        checks++; if (buzzer !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL snooze_rering: got buzzer %0d state %0d expected 1/2", buzzer, state_o); end
        stop_btn = 1'b0;
        ticks(3);
        stop_btn = 1'b1;
        ticks(3);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL snooze_stop: got %0d expected 1", state_o); end
    endtask
`else
    task automatic test_snooze_ignored();
        arm_and_ring(23, 58);
        snooze_btn = 1'b0;
        ticks(6);
        snooze_btn = 1'b1;
        checks++; if (state_o !== 2'd2 || snooze_active !== 1'b0) begin errors++; $display("FAIL snooze_ignored: got state %0d snz %0d expected 2/0", state_o, snooze_active); end
        stop_btn = 1'b0;
        ticks(3);
        stop_btn = 1'b1;
        ticks(3);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL snooze_off_stop: got %0d expected 1", state_o); end
    endtask
`endif

    task automatic test_disable();
        arm_and_ring(9, 15);
        alarm_enable = 1'b0;
        tick();
        checks++; if (state_o !== 2'd0 || buzzer !== 1'b0 || alarm_armed !== 1'b0) begin errors++; $display("FAIL disable_idle: got state %0d buzzer %0d expected 0/0", state_o, buzzer); end
        alarm_enable = 1'b1;
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL disable_rearm: got %0d expected 1", state_o); end
    endtask

    task automatic test_reset_mid_ring();
        arm_and_ring(10, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({buzzer, alarm_armed, snooze_active, state_o} !== 5'd0) begin errors++; $display("FAIL midring_reset: got b%0d a%0d s%0d st%0d expected all 0", buzzer, alarm_armed, snooze_active, state_o); end
        checks++; if ({alarm_hours, alarm_minutes} !== 11'd0) begin errors++; $display("FAIL midring_reset_time: got %0d:%0d expected 0:0", alarm_hours, alarm_minutes); end
        tick();
    endtask

    task automatic test_random();
        int r, t;
        logic [1:0] e_state;
        for (int cyc = 0; cyc < 4000 && errors < 40; cyc++) begin
            rst      = ($urandom_range(0, 999) == 0);
            sec_tick = ($urandom_range(0, 2) == 0);
            if (alarm_enable) alarm_enable = ($urandom_range(0, 199) != 0);
            else alarm_enable = ($urandom_range(0, 9) == 0);
            set_alarm = ($urandom_range(0, 79) == 0);
            alarm_hours_in   = 5'($urandom_range(0, MH - 1));
            alarm_minutes_in = 6'($urandom_range(0, MM - 1));
            r = $urandom_range(0, 19);
            t = -1;
            if (r < 4) t = m_tgt;
            else if (r == 4) t = m_saved;
            else if (r == 5) t = (m_tgt + 1) % (MM * MH);
            else if (r == 6) t = $urandom_range(0, MM * MH - 1);
            if (t >= 0) set_time(t / MM, t % MM);
            if ($urandom_range(0, 14) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 14) == 0) snooze_btn = ~snooze_btn;
            tick();
            e_state = 2'(m_state);
            checks++; if (state_o !== e_state) begin errors++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", cyc, state_o, e_state); end
            checks++; if (buzzer !== (m_state == 2)) begin errors++; $display("FAIL rnd_buzzer cyc %0d: got %0d expected %0d", cyc, buzzer, m_state == 2); end
            checks++; if (alarm_armed !== (m_state == 1 || m_state == 3)) begin errors++; $display("FAIL rnd_armed cyc %0d: got %0d expected %0d", cyc, alarm_armed, m_state == 1 || m_state == 3); end
            checks++; if (snooze_active !== (m_state == 3)) begin errors++; $display("FAIL rnd_snooze cyc %0d: got %0d expected %0d", cyc, snooze_active, m_state == 3); end
            checks++; if (int'(alarm_hours) != m_saved / MM || int'(alarm_minutes) != m_saved % MM) begin errors++; $display("FAIL rnd_saved cyc %0d: got %0d:%0d expected %0d:%0d", cyc, alarm_hours, alarm_minutes, m_saved / MM, m_saved % MM); end
        end
        rst = 1'b0; sec_tick = 1'b0; set_alarm = 1'b0;
        stop_btn = 1'b1; snooze_btn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_ring();
        test_timeout();
        test_button_priority();
        test_set_while_ringing();
`ifdef ALARM_SNOOZE_EN
        test_snooze_wrap();
`else
        test_snooze_ignored();
`endif
        test_disable();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ring_scheduler.md
# alarm_ring_scheduler

Holds the saved alarm time, compares it against the running clock and sequences the buzzer through arm, ring, snooze and timeout. It sits between the settings controller, which supplies `set_alarm` and the edited hours/minutes, and the time counter. It drives the buzzer output and the alarm status indicators.

## Interface
- `MAX_MINUTES`, 60, minutes per hour; minute fields are `$clog2(MAX_MINUTES)` bits wide
- `MAX_HOURS`, 24, hours per day; hour fields are `$clog2(MAX_HOURS)` bits wide
- `RING_SECONDS`, 60, ring timeout in `sec_tick` pulses, ≥1
- `SNOOZE_MINUTES`, 5, snooze delay, 1..MAX_MINUTES-1
- `clk` in 1 — 50 MHz system clock; one clock domain
- `rst` in 1 — synchronous, active-high reset
- `sec_tick` in 1 — one-cycle pulse, once per second
- `cur_minutes` in `$clog2(MAX_MINUTES)` — current time, minutes
- `cur_hours` in `$clog2(MAX_HOURS)` — current time, hours
- `alarm_enable` in 1 — level switch; 1 means the alarm is active
- `set_alarm` in 1 — one-cycle strobe that loads the new alarm time
- `alarm_minutes_in` in `$clog2(MAX_MINUTES)` — new alarm minutes
- `alarm_hours_in` in `$clog2(MAX_HOURS)` — new alarm hours
- `stop_btn` in 1 — active-low push button, asynchronous to `clk`
- `snooze_btn` in 1 — active-low push button, asynchronous to `clk`
- `buzzer` out 1 — 1 while in RINGING
- `alarm_armed` out 1 — 1 in ARMED or SNOOZE
- `snooze_active` out 1 — 1 in SNOOZE
- `alarm_minutes` out `$clog2(MAX_MINUTES)` — saved alarm minutes
- `alarm_hours` out `$clog2(MAX_HOURS)` — saved alarm hours
- `state_o` out 2 — encoded state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

## Operation
- **Registers:** `alarm_minutes`/`alarm_hours` (saved time), `tgt_min`/`tgt_hr` (active target), `fired` latch, ring second counter, FSM state.
- **Reset:** all outputs 0, state IDLE, saved time 00:00, target 00:00, `fired`=0, counter 0.
- **`set_alarm`:** saved time and target both load the inputs, `fired` clears. Accepted in every state. When `alarm_enable`=1 the next state is ARMED, which also aborts RINGING and SNOOZE.
- **Match:** `match` = (`cur_hours`==`tgt_hr`) && (`cur_minutes`==`tgt_min`) && !`fired`.
- **`fired`:** sets on entry to RINGING. Clears when the current time differs from the target. This prevents re-triggering within the same minute.
- **IDLE:**
  - to ARMED on `alarm_enable`=1
  - the target reloads from the saved time
- **ARMED:** to RINGING on `match`; the ring counter clears.
- **RINGING:**
  - counter increments on each `sec_tick`
  - stop press → ARMED, target restored to the saved time
  - snooze press → SNOOZE; target = current time + `SNOOZE_MINUTES`, minutes wrap mod `MAX_MINUTES` with carry into hours, hours wrap mod `MAX_HOURS` (23:58 + 5 → 00:03)
  - counter reaches `RING_SECONDS` → ARMED, target restored to the saved time
- **SNOOZE:**
  - to RINGING on `match`
  - stop press → ARMED, target restored to the saved time
- **Any state:** `alarm_enable`=0 forces IDLE next cycle, `buzzer` off. Priority: rst > `alarm_enable`=0 > `set_alarm` > stop > snooze > timeout > match.
- **Buttons:**
  - each button passes through a 2-FF synchronizer, then a falling-edge detector
  - synchronizer FFs reset to 1 (released)
  - a held button produces exactly one press
- **Arithmetic:** the snooze sum is computed one bit wider than the field, then a conditional subtract is applied. No modulo operator.

## Timing
- Match to `buzzer`=1: registered; `buzzer` rises on the clock edge after the first cycle in which `match` is true.
- Button low at the pin to FSM state change: 3 `clk` edges (2 synchronizer, 1 edge/FSM).
- Timeout: `buzzer` falls on the edge after the `RING_SECONDS`-th `sec_tick` counted in RINGING.
- `set_alarm` to new `alarm_minutes`/`alarm_hours`: 1 cycle.
- Reset asserted mid-ring: `buzzer` is 0 after the next edge.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** behaviour as above.
- **`ALARM_SNOOZE_EN` undefined:**
  - SNOOZE state and the snooze adder are removed
  - `snooze_btn` is ignored (its synchronizer is not instantiated)
  - `snooze_active` is tied to 0
  - `state_o` never equals 3

## Structure
- **Shared package `clock_pkg`:**
  - `alarm_state_t` enum (2-bit encodings as above)
  - `MAX_MINUTES`/`MAX_HOURS` default constants
  - `MIN_W`/`HR_W` width constants
- **Sub-module `btn_press_detect`:** 2-FF synchronizer plus falling-edge pulse. Instantiated once per button.
- **FSM:** one sequential block plus one next-state combinational block in the top.

## Test plan
- **Basic ring:** alarm set to 07:30, enable=1, time steps to 07:30 → `buzzer`=1 one cycle later, `state_o`=2.
- **Snooze wrap:** ringing at 23:58, snooze pressed → `state_o`=3, target 00:03. Time reaches 00:03 → `buzzer`=1 again.
- **Timeout:** `RING_SECONDS`=4, no button presses → `buzzer` falls after the 4th `sec_tick`, `state_o`=1. Still within the alarm minute → no re-ring.
- **Button priority:** stop and snooze pressed in the same cycle while ringing → ARMED, `snooze_active`=0.
- **`set_alarm` while ringing:** new time 08:00 → `buzzer`=0, `alarm_hours`=8, `alarm_minutes`=0, `state_o`=1.
- **Reset and disable:** `rst` pulsed mid-ring → all outputs 0, `state_o`=0. Separately, enable dropped while ringing → IDLE next cycle.
